// File: rtl/ili9341_spi_receiver.sv
// Panel-side ILI9341 4-wire 8-bit SPI responder: oversamples the link, decodes
// window/RAMWR commands and streams RGB565 pixels into a framebuffer write port.
module ili9341_spi_receiver #(
    parameter int unsigned DISPLAY_WIDTH  = 240,
    parameter int unsigned DISPLAY_HEIGHT = 320,
    parameter int unsigned VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_csb,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    input  logic                      data_commandb,
    output logic                      spi_miso,
    output logic                      vram_wr_ena,
    output logic [$clog2(VRAM_L)-1:0] vram_wr_addr,
    output logic [15:0]               vram_wr_data,
    output logic                      cmd_valid,
    output logic [7:0]                cmd_byte,
    output logic                      frame_done
);

    localparam int unsigned AW     = $clog2(VRAM_L);
    localparam logic [15:0] W16    = 16'(DISPLAY_WIDTH);
    localparam logic [15:0] H16    = 16'(DISPLAY_HEIGHT);
    localparam logic [15:0] W_LAST = 16'(DISPLAY_WIDTH - 1);
    localparam logic [15:0] H_LAST = 16'(DISPLAY_HEIGHT - 1);

    typedef enum logic [1:0] {S_CMD, S_CASET, S_PASET, S_RAMWR} state_t;

    state_t      state_q, state_d;
    logic [1:0]  csb_sy, sclk_sy, mosi_sy, dc_sy;
    logic        sclk_prev, csb_prev;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        byte_valid, byte_dc;
    logic [7:0]  byte_data;
    logic [2:0]  arg_idx;
    logic [15:0] s_tmp;
    logic [7:0]  e_hi;
    logic [15:0] sc, ec, sp, ep, cur_x, cur_y;
    logic [7:0]  pix_hi;
    logic        pending;

    logic        edge_ok_c, is_cmd_c, is_data_c, win_ok_c;
    logic [15:0] arg_end_c, ec_clamp_c, ep_clamp_c;
    logic [AW-1:0] addr_c;

    assign spi_miso = 1'b0;

    // Edge seen while csb was low a cycle ago still counts, so a byte whose
    // 8th edge coincides with csb rising is completed rather than discarded.
    assign edge_ok_c  = sclk_sy[1] & ~sclk_prev & (~csb_sy[1] | ~csb_prev);
    assign is_cmd_c   = byte_valid & ~byte_dc;
    assign is_data_c  = byte_valid & byte_dc;
    assign win_ok_c   = (sc <= ec) && (sp <= ep) && (sc < W16) && (sp < H16);
    assign arg_end_c  = {e_hi, byte_data};
    assign ec_clamp_c = (arg_end_c >= W16) ? W_LAST : arg_end_c;
    assign ep_clamp_c = (arg_end_c >= H16) ? H_LAST : arg_end_c;
    assign addr_c     = AW'(32'(cur_y) * DISPLAY_WIDTH + 32'(cur_x));

    // Synchronizers and byte assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csb_sy     <= 2'b11;
            sclk_sy    <= 2'b00;
            mosi_sy    <= 2'b00;
            dc_sy      <= 2'b00;
            sclk_prev  <= 1'b0;
            csb_prev   <= 1'b1;
            bit_cnt    <= 3'd0;
            shift      <= 8'd0;
            byte_valid <= 1'b0;
            byte_dc    <= 1'b0;
            byte_data  <= 8'd0;
        end else begin
            csb_sy     <= {csb_sy[0], spi_csb};
            sclk_sy    <= {sclk_sy[0], spi_clk};
            mosi_sy    <= {mosi_sy[0], spi_mosi};
            dc_sy      <= {dc_sy[0], data_commandb};
            sclk_prev  <= sclk_sy[1];
            csb_prev   <= csb_sy[1];
            byte_valid <= 1'b0;
            if (edge_ok_c) begin
                shift   <= {shift[6:0], mosi_sy[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shift[6:0], mosi_sy[1]};
                    byte_dc    <= dc_sy[1];
                end
            end else if (csb_sy[1]) begin
                bit_cnt <= 3'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_CMD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (is_cmd_c) begin
            case (byte_data)
                8'h2A:   state_d = S_CASET;
                8'h2B:   state_d = S_PASET;
                8'h2C:   state_d = S_RAMWR;
                default: state_d = S_CMD;
            endcase
        end
    end

    // Window, cursor and pixel write datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vram_wr_ena  <= 1'b0;
            vram_wr_addr <= '0;
            vram_wr_data <= 16'd0;
            cmd_valid    <= 1'b0;
            cmd_byte     <= 8'd0;
            frame_done   <= 1'b0;
            arg_idx      <= 3'd0;
            s_tmp        <= 16'd0;
            e_hi         <= 8'd0;
            sc           <= 16'd0;
            ec           <= W_LAST;
            sp           <= 16'd0;
            ep           <= H_LAST;
            cur_x        <= 16'd0;
            cur_y        <= 16'd0;
            pix_hi       <= 8'd0;
            pending      <= 1'b0;
        end else begin
            vram_wr_ena <= 1'b0;
            cmd_valid   <= 1'b0;
            frame_done  <= 1'b0;
            if (is_cmd_c) begin
                cmd_valid <= 1'b1;
                cmd_byte  <= byte_data;
                arg_idx   <= 3'd0;
                pending   <= 1'b0;
                if (byte_data == 8'h2C) begin
                    cur_x <= sc;
                    cur_y <= sp;
                end else if (byte_data == 8'h01) begin
                    sc    <= 16'd0;
                    ec    <= W_LAST;
                    sp    <= 16'd0;
                    ep    <= H_LAST;
                    cur_x <= 16'd0;
                    cur_y <= 16'd0;
                end
            end else if (is_data_c) begin
                case (state_q)
                    S_CASET, S_PASET: begin
                        if (arg_idx < 3'd4) begin
                            arg_idx <= arg_idx + 3'd1;
                            case (arg_idx)
                                3'd0: s_tmp[15:8] <= byte_data;
                                3'd1: s_tmp[7:0]  <= byte_data;
                                3'd2: e_hi        <= byte_data;
                                default: begin
                                    if (state_q == S_CASET) begin
                                        sc <= s_tmp;
                                        ec <= ec_clamp_c;
                                    end else begin
                                        sp <= s_tmp;
                                        ep <= ep_clamp_c;
                                    end
                                end
                            endcase
                        end
                    end
                    S_RAMWR: begin
                        if (win_ok_c) begin
                            if (!pending) begin
                                pix_hi  <= byte_data;
                                pending <= 1'b1;
                            end else begin
                                pending      <= 1'b0;
                                vram_wr_ena  <= 1'b1;
                                vram_wr_data <= {pix_hi, byte_data};
                                vram_wr_addr <= addr_c;
                                if (cur_x == ec) begin
                                    cur_x <= sc;
                                    if (cur_y == ep) begin
                                        cur_y      <= sp;
                                        frame_done <= 1'b1;
                                    end else begin
                                        cur_y <= cur_y + 16'd1;
                                    end
                                end else begin
                                    cur_x <= cur_x + 16'd1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/ili9341_spi_receiver.md
Name: ili9341_spi_receiver

Overview:
- Synthesizable model of the panel end of the ILI9341 4-wire 8-bit SPI link: the responder to the display controller.
- Oversamples csb/sclk/mosi/data_commandb in the system clock domain and assembles bytes.
- Decodes NOP, SWRESET, CASET, PASET and RAMWR, then writes RGB565 pixels into a framebuffer write port.
- Used as a loopback target in benches and as a display emulator feeding a VRAM-backed video path.

Parameters:
- DISPLAY_WIDTH, 240, columns.
- DISPLAY_HEIGHT, 320, rows.
- VRAM_L, DISPLAY_WIDTH*DISPLAY_HEIGHT, framebuffer depth.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- spi_csb  input  1  chip select, active low.
- spi_clk  input  1  SPI clock, mode 0, at most clk/4.
- spi_mosi  input  1  serial data, MSB first.
- data_commandb  input  1  1 = data byte, 0 = command byte.
- spi_miso  output  1  tied 0 (reads unsupported).
- vram_wr_ena  output  1  one-cycle pixel write strobe.
- vram_wr_addr  output  $clog2(VRAM_L)  pixel address, y*DISPLAY_WIDTH+x.
- vram_wr_data  output  16  RGB565 pixel.
- cmd_valid  output  1  one-cycle pulse per decoded command byte.
- cmd_byte  output  8  last command byte; held until the next command.
- frame_done  output  1  one-cycle pulse on the write of the last pixel in the window.

Behaviour:
- Reset values: all outputs 0; window SC=0, EC=DISPLAY_WIDTH-1, SP=0, EP=DISPLAY_HEIGHT-1; cursor (0,0); decode state S_CMD.
- Input capture:
  - 2-FF synchronizers on all four SPI inputs.
  - Sclk rising edge = synced sclk 1 now and 0 on the previous cycle.
  - On a rising edge with synced csb low: shift mosi in and increment a 3-bit bit counter.
  - data_commandb is sampled on the 8th bit.
  - A byte is complete on the 8th edge and raises an internal byte_valid for exactly 1 cycle.
- Synced csb high clears the bit counter and discards any partial byte. Decode state and the pending-pixel flag persist across csb toggles.
- Any command byte (dc=0), in any state:
  - Pulses cmd_valid and loads cmd_byte.
  - Clears the argument index and the pending-pixel flag.
  - Transitions state:
    - 0x2A goes to S_CASET.
    - 0x2B goes to S_PASET.
    - 0x2C goes to S_RAMWR and loads cursor (SC,SP).
    - 0x01 restores reset window/cursor, then S_CMD.
    - 0x00 and all other commands go to S_CMD. Their data bytes are ignored, including the ROM init argument bytes.
- S_CASET, data bytes:
  - Index 0..3 fill SC[15:8], SC[7:0], EC[15:8], EC[7:0].
  - Values are committed on the 4th byte.
  - EC >= DISPLAY_WIDTH is clamped to DISPLAY_WIDTH-1.
  - Bytes after the 4th are ignored.
- S_PASET: same as S_CASET for SP/EP against DISPLAY_HEIGHT.
- Invalid window: SC>EC or SP>EP, or SC/SP out of range. RAMWR data is then dropped with no writes.
- S_RAMWR, data bytes:
  - First byte goes to the high byte and sets the pending flag.
  - Second byte completes the pixel. On the next cycle:
    - vram_wr_ena=1.
    - vram_wr_data={hi,lo}.
    - vram_wr_addr=y*DISPLAY_WIDTH+x.
  - Cursor advance after each pixel:
    - x<EC: x+1.
    - Else x=SC and y+1.
    - At x==EC and y==EP: frame_done pulses with that write and the cursor wraps to (SC,SP).
  - Stream continues indefinitely.
- Latency: 8th sclk edge to vram_wr_ena is 4 clk cycles max (2 sync, 1 edge detect, 1 register), fixed.
- Simultaneous events: csb rising in the same cycle as the 8th edge still completes the byte. Edge processing has priority over the clear.
- Async rst mid-byte or mid-frame: immediate return to reset values. The first byte after release starts a new byte.

Test Plan:
- Reset release: all outputs 0 and spi_miso 0. Drive RAMWR, then 0xF800, 0x07E0 -> writes addr 0 data 0xF800, then addr 1 data 0x07E0; cmd_byte=0x2C.
- Full default frame: RAMWR plus 76800 pixels of value i -> frame_done only with addr 76799. Pixel 76801 -> addr 0.
- Window:
  - Drive CASET 0x000A,0x000C; PASET 0x0005,0x0006; RAMWR; then 7 pixels.
  - Required addrs: 1210, 1211, 1212, 1450, 1451, 1452. frame_done on 1452.
  - 7th pixel -> 1210.
  - SWRESET, then RAMWR -> addr 0.
- Abort cases:
  - csb high after 5 bits, then full byte 0xAB as the pixel high byte -> pixel uses 0xAB.
  - Command byte after a pixel high byte -> no write; next pixel pair is aligned.
- Init sequence: ROM-style commands with arguments (0xC0 0x23, 0x11, 0x29) -> 3 cmd_valid pulses, no vram writes.
- Async reset mid-frame at pixel 100 -> outputs 0 immediately. RAMWR, then 1 pixel -> addr 0.
